stab_inject_arbiter: RTL and testbench

- Shares the single network injection port (data/valid/ready "stab" channel of `system`) between NREQ packet sources.
- Round-robin arbitration at packet granularity: a grant is held from the first flit to the flit marked last.
- Output is registered through a 2-entry skid buffer so the stab ready path is cut.
- Carries an on-chip stall watchdog that replaces bench-side deadlock detection.

---
 rtl/noc_arb_pkg.sv | 58 +++++
 rtl/stab_skid_buf.sv | 59 +++++
 rtl/stab_inject_arbiter.sv | 149 ++++++++++++++
 tb/tb_stab_inject_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the network injection arbiter.
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned WD_WIN_DEF = 10000;
  localparam int unsigned NREQ_MAX   = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SUM_W      = IDX_W + 1;

  // Round-robin pick: first set bit of req at or after ptr, wrapping at n.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                                  input logic [IDX_W-1:0]    ptr,
                                                  input int unsigned         n);
    logic [NREQ_MAX-1:0] gnt;
    logic                found;
    logic [SUM_W-1:0]    sum;
    logic [IDX_W-1:0]    idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ_MAX; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(n)) sum = sum - SUM_W'(n);
      idx = sum[IDX_W-1:0];
      if ((i < n) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NREQ_MAX-1:0] oh);
    logic [NREQ_MAX-1:0] t;
    logic [IDX_W-1:0]    idx;
    t   = oh;
    idx = '0;
    for (int unsigned i = 0; i < NREQ_MAX; i++) begin
      if (t[0]) idx = IDX_W'(i);
      t = t >> 1;
    end
    return idx;
  endfunction

  // Successor of idx modulo n.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int unsigned      n);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, idx} + SUM_W'(1);
    if (sum >= SUM_W'(n)) sum = '0;
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/stab_skid_buf.sv
// Two-entry valid/ready FIFO; all outputs come straight from flops.
module stab_skid_buf #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] spare;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic          push;
  logic          pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (!push && pop) begin
      count_nxt = count - 2'd1;
    end
  end

  // Head entry drives the output; spare holds the second flit while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      spare     <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          out_data <= in_data;
        end else begin
          spare <= in_data;
        end
      end
      if (pop && (count == 2'd2)) begin
        out_data <= spare;
      end
      count     <= count_nxt;
      in_ready  <= (count_nxt != 2'd2);
      out_valid <= (count_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/stab_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing the stab injection port,
// with a registered skid buffer and a stall watchdog.
module stab_inject_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned WD_WIN = WD_WIN_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [DW-1:0]     data_o_stab,
  output logic              valid_o_stab,
  input  logic              ready_i_stab,
  output logic [NREQ-1:0]   grant_o,
  output logic [CNT_W-1:0]  flit_cnt_o,
  output logic              deadlock_o
);

  localparam int unsigned WD_W = (WD_WIN > 2) ? $clog2(WD_WIN) : 1;

  arb_state_e          state;
  arb_state_e          state_nxt;
  logic [NREQ-1:0]     grant_nxt;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IDX_W-1:0]    ptr_after;
  logic [NREQ-1:0]     pick_idle;
  logic [NREQ-1:0]     pick_next;
  logic [NREQ*DW-1:0]  masked_data;
  logic [DW-1:0]       owner_data;
  logic                owner_valid;
  logic                owner_last;
  logic                buf_ready;
  logic                accept;
  logic                out_hs;
  logic [WD_W-1:0]     wd_cnt;

  // Keep only the owner's flit on the shared data path.
  for (genvar g = 0; g < NREQ; g++) begin : g_mask
    assign masked_data[g*DW +: DW] = req_data_i[g*DW +: DW] & {DW{grant_o[g]}};
  end

  // OR-fold the masked source lanes into the owner's flit.
  always_comb begin
    logic [NREQ*DW-1:0] t;
    owner_data = '0;
    t          = masked_data;
    for (int unsigned k = 0; k < NREQ; k++) begin
      owner_data = owner_data | t[DW-1:0];
      t          = t >> DW;
    end
  end

  assign owner_valid = |(req_valid_i & grant_o);
  assign owner_last  = |(req_last_i & grant_o);
  assign req_ready_o = grant_o & {NREQ{buf_ready}};
  assign accept      = owner_valid & buf_ready;
  assign out_hs      = valid_o_stab & ready_i_stab;

  assign ptr_after = rr_next(onehot_idx(NREQ_MAX'(grant_o)), NREQ);
  assign pick_idle = NREQ'(rr_pick(NREQ_MAX'(req_valid_i), ptr, NREQ));
  assign pick_next = NREQ'(rr_pick(NREQ_MAX'(req_valid_i & ~grant_o), ptr_after, NREQ));

  // Arbiter state, owner and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB_IDLE;
      grant_o <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      grant_o <= grant_nxt;
      ptr     <= ptr_nxt;
    end
  end

  // Next owner: pick from idle, or hand over on the owner's tail flit.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    ptr_nxt   = ptr;
    unique case (state)
      ARB_IDLE: begin
        if (|req_valid_i) begin
          state_nxt = ARB_LOCK;
          grant_nxt = pick_idle;
        end
      end
      ARB_LOCK: begin
        if (accept && owner_last) begin
          ptr_nxt = ptr_after;
          if (|pick_next) begin
            grant_nxt = pick_next;
          end else begin
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  stab_skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (owner_data),
    .in_valid  (owner_valid),
    .in_ready  (buf_ready),
    .out_data  (data_o_stab),
    .out_valid (valid_o_stab),
    .out_ready (ready_i_stab)
  );

  // Count flits taken by the network; wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flit_cnt_o <= '0;
    end else if (out_hs) begin
      flit_cnt_o <= flit_cnt_o + CNT_W'(1);
    end
  end

  // Stall watchdog: consecutive valid-without-ready cycles, sticky flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt     <= '0;
      deadlock_o <= 1'b0;
    end else if (!(valid_o_stab && !ready_i_stab)) begin
      wd_cnt <= '0;
    end else if (wd_cnt == WD_W'(WD_WIN - 1)) begin
      deadlock_o <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_stab_inject_arbiter.sv
// Directed bench for stab_inject_arbiter: source queues, output scoreboard.
module tb_stab_inject_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned WD_WIN = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEPTH  = 64;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_last_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [DW-1:0]      data_o_stab;
  logic               valid_o_stab;
  logic               ready_i_stab;
  logic [NREQ-1:0]    grant_o;
  logic [CNT_W-1:0]   flit_cnt_o;
  logic               deadlock_o;

  logic          src_valid [NREQ];
  logic          src_last  [NREQ];
  logic [DW-1:0] src_data  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_data_i[g*DW +: DW] = src_data[g];
    assign req_valid_i[g]         = src_valid[g];
    assign req_last_i[g]          = src_last[g];
  end

  always #5 clk = ~clk;

  stab_inject_arbiter #(
    .NREQ   (NREQ),
    .DW     (DW),
    .WD_WIN (WD_WIN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .data_o_stab  (data_o_stab),
    .valid_o_stab (valid_o_stab),
    .ready_i_stab (ready_i_stab),
    .grant_o      (grant_o),
    .flit_cnt_o   (flit_cnt_o),
    .deadlock_o   (deadlock_o)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    sdata [NREQ][DEPTH];
  logic             slast [NREQ][DEPTH];
  int               shead [NREQ];
  int               stail [NREQ];
  logic             en    [NREQ];
  logic             in_pkt[NREQ];
  logic [DW-1:0]    expq[$];
  int               own_log[$];
  int               occ;
  logic [CNT_W-1:0] cnt_m;
  int               cyc;
  int               rdy_mode;
  int               first_out;
  int               last_out;
  int               full_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] enc(input int s, input int p, input int i);
    return {4'(s + 1), 4'(p), 8'(i)};
  endfunction

  task automatic add_pkt(input int s, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      sdata[s][stail[s]] = enc(s, p, i);
      slast[s][stail[s]] = (i == n - 1);
      stail[s]++;
    end
  endtask

  function automatic int pending();
    int n;
    n = expq.size();
    for (int k = 0; k < NREQ; k++) n += stail[k] - shead[k];
    return n;
  endfunction

  // One clock: drive sources, note handshakes, advance models, check outputs.
  task automatic tick();
    logic [NREQ-1:0] hs;
    logic            ohs;
    logic [DW-1:0]   od;
    logic [DW-1:0]   e;
    int              busy;
    for (int k = 0; k < NREQ; k++) begin
      if (en[k] && (shead[k] != stail[k])) begin
        src_valid[k] = 1'b1;
        src_data[k]  = sdata[k][shead[k]];
        src_last[k]  = slast[k][shead[k]];
      end else begin
        src_valid[k] = 1'b0;
        src_last[k]  = 1'b0;
      end
    end
    case (rdy_mode)
      0:       ready_i_stab = 1'b1;
      1:       ready_i_stab = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: ready_i_stab = 1'b0;
    endcase
    #4;
    hs  = req_valid_i & req_ready_o;
    ohs = valid_o_stab & ready_i_stab;
    od  = data_o_stab;
    @(posedge clk);
    #1;
    if (ohs) begin
      chk("out_pending", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_order", 64'(od), 64'(e));
      end
      occ--;
      cnt_m++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (hs[k]) begin
        busy = 0;
        for (int j = 0; j < NREQ; j++) if (j != k && in_pkt[j]) busy++;
        chk("pkt_lock", 64'(busy), 64'd0);
        if (!in_pkt[k]) own_log.push_back(k);
        expq.push_back(sdata[k][shead[k]]);
        in_pkt[k] = !slast[k][shead[k]];
        shead[k]++;
        occ++;
      end
    end
    cyc++;
    chk("occ_le2", 64'(occ <= 2), 64'd1);
    chk("valid_vs_occ", 64'(valid_o_stab), 64'(occ != 0));
    chk("ready_onehot0", 64'($onehot0(req_ready_o)), 64'd1);
    if (occ == 2) begin
      full_seen++;
      chk("ready_drop_full", 64'(req_ready_o), 64'd0);
    end
    chk("flit_cnt", 64'(flit_cnt_o), 64'(cnt_m));
  endtask

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while ((pending() > 0) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      src_valid[k] = 1'b0;
      src_last[k]  = 1'b0;
      src_data[k]  = '0;
      shead[k]     = 0;
      stail[k]     = 0;
      en[k]        = 1'b1;
      in_pkt[k]    = 1'b0;
    end
    expq.delete();
    own_log.delete();
    occ          = 0;
    cnt_m        = '0;
    cyc          = 0;
    rdy_mode     = 0;
    first_out    = -1;
    last_out     = -1;
    full_seen    = 0;
    ready_i_stab = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int exp_own[5];
    exp_own = '{0, 1, 2, 3, 0};

    // Reset state
    rstn         = 1'b0;
    ready_i_stab = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      src_valid[k] = 1'b0;
      src_last[k]  = 1'b0;
      src_data[k]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_valid", 64'(valid_o_stab), 64'd0);
    chk("rst_data", 64'(data_o_stab), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_flit_cnt", 64'(flit_cnt_o), 64'd0);
    chk("rst_deadlock", 64'(deadlock_o), 64'd0);

    // Single source: three 4-flit packets from source 0
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(0, p, 4);
    tick();
    chk("t1_grant", 64'(grant_o), 64'b0001);
    chk("t1_no_out_at_decision", 64'(valid_o_stab), 64'd0);
    tick();
    chk("t1_first_valid", 64'(valid_o_stab), 64'd1);
    chk("t1_first_data", 64'(data_o_stab), 64'h1000);
    run("t1_drain", 200);
    chk("t1_flit_cnt", 64'(flit_cnt_o), 64'd12);

    // Contention: all four sources with two 2-flit packets each
    do_reset();
    for (int s = 0; s < 4; s++) begin
      add_pkt(s, 0, 2);
      add_pkt(s, 1, 2);
    end
    run("t2_drain", 200);
    chk("t2_owner_count", 64'(own_log.size()), 64'd8);
    for (int i = 0; i < 5 && i < own_log.size(); i++) chk("t2_owner_order", 64'(own_log[i]), 64'(exp_own[i]));
    chk("t2_no_bubble", 64'(last_out - first_out), 64'd15);
    chk("t2_flit_cnt", 64'(flit_cnt_o), 64'd16);

    // Packet lock: source 2 mid-packet while 0 and 3 raise valid
    do_reset();
    add_pkt(2, 0, 3);
    add_pkt(0, 0, 2);
    add_pkt(3, 0, 2);
    en[0] = 1'b0;
    en[3] = 1'b0;
    tick();
    tick();
    en[0] = 1'b1;
    en[3] = 1'b1;
    tick();
    chk("t3_lock_grant", 64'(grant_o), 64'b0100);
    chk("t3_src0_blocked", 64'(req_ready_o[0]), 64'd0);
    tick();
    chk("t3_next_owner", 64'(grant_o), 64'b1000);
    run("t3_drain", 100);
    chk("t3_owner_count", 64'(own_log.size()), 64'd3);
    if (own_log.size() == 3) begin
      chk("t3_owner0", 64'(own_log[0]), 64'd2);
      chk("t3_owner1", 64'(own_log[1]), 64'd3);
      chk("t3_owner2", 64'(own_log[2]), 64'd0);
    end

    // Back-pressure: ready pattern 1,0,0,1 over a 20-flit stream
    do_reset();
    rdy_mode = 1;
    for (int p = 0; p < 5; p++) add_pkt(1, p, 4);
    run("t4_drain", 300);
    chk("t4_flit_cnt", 64'(flit_cnt_o), 64'd20);
    chk("t4_full_seen", 64'(full_seen > 0), 64'd1);

    // Watchdog: one flit held with ready low
    do_reset();
    rdy_mode = 2;
    add_pkt(3, 0, 1);
    tick();
    tick();
    chk("t5_stalled_valid", 64'(valid_o_stab), 64'd1);
    chk("t5_no_flag_yet", 64'(deadlock_o), 64'd0);
    repeat (15) tick();
    chk("t5_before_window", 64'(deadlock_o), 64'd0);
    tick();
    chk("t5_rise", 64'(deadlock_o), 64'd1);
    rdy_mode = 0;
    run("t5_drain", 20);
    chk("t5_sticky", 64'(deadlock_o), 64'd1);
    chk("t5_flit_cnt", 64'(flit_cnt_o), 64'd1);
    do_reset();
    chk("t5_cleared", 64'(deadlock_o), 64'd0);

    // Reset mid-packet, then a fresh packet from source 1
    add_pkt(1, 0, 4);
    tick();
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_req_ready", 64'(req_ready_o), 64'd0);
    chk("t6_valid", 64'(valid_o_stab), 64'd0);
    chk("t6_data", 64'(data_o_stab), 64'd0);
    chk("t6_grant", 64'(grant_o), 64'd0);
    chk("t6_flit_cnt", 64'(flit_cnt_o), 64'd0);
    chk("t6_deadlock", 64'(deadlock_o), 64'd0);
    @(posedge clk);
    #1;
    do_reset();
    add_pkt(1, 1, 2);
    tick();
    chk("t6_regrant", 64'(grant_o), 64'b0010);
    run("t6_drain", 50);
    chk("t6_restart_cnt", 64'(flit_cnt_o), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
